// File: rtl/mcpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mcpu_ctrl_pkg : opcode/funct constants, state and select encodings for the
//                 MicroCPU multi-cycle controller.
// Revision      : 1.0
// ============================================================================
package mcpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        CL_R   = 4'd0,
        CL_I   = 4'd1,
        CL_LW  = 4'd2,
        CL_SW  = 4'd3,
        CL_BEQ = 4'd4,
        CL_BNE = 4'd5,
        CL_J   = 4'd6,
        CL_SYS = 4'd7,
        CL_ILL = 4'd8
    } cls_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_if : controller <-> datapath signal bundle.
//                      MEM_READY_EN adds the MemReady handshake input.
// Revision           : 1.0
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int OP_W = 6,
    parameter int FN_W = 6,
    parameter int ST_W = 4
);
    logic            Go;
    logic [OP_W-1:0] Op;
    logic [FN_W-1:0] Funct;
    logic            Zero;
`ifdef MEM_READY_EN
    logic            MemReady;
`endif
    logic            PCWrite;
    logic            IRWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            RegWrite;
    logic            RegDst;
    logic            MemToReg;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [2:0]      ALUOp;
    logic [1:0]      ExtOp;
    logic [1:0]      PCSrc;
    logic            Halted;
    logic            IllegalOp;
    logic [ST_W-1:0] State;

    modport master (
        input  Go, Op, Funct, Zero,
`ifdef MEM_READY_EN
        input  MemReady,
`endif
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
        output ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, Halted, IllegalOp, State
    );

    modport slave (
        output Go, Op, Funct, Zero,
`ifdef MEM_READY_EN
        output MemReady,
`endif
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
        input  ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, Halted, IllegalOp, State
    );
endinterface
`default_nettype wire

// File: rtl/mcpu_op_decode.sv
`default_nettype none
// ============================================================================
// mcpu_op_decode : Op/Funct -> instruction class, ExtOp and I-type ALUOp.
// Revision       : 1.0
// ============================================================================
module mcpu_op_decode
    import mcpu_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [FN_W-1:0] funct_i,
    output cls_t            cls_o,
    output logic [1:0]      ext_op_o,
    output logic [2:0]      alu_op_o
);
    always_comb begin
        cls_o    = CL_ILL;
        ext_op_o = EXT_ZERO;
        alu_op_o = ALU_ADD;
        case (op_i)
            OP_RTYPE: cls_o = (funct_i == FN_SYSCALL) ? CL_SYS : CL_R;
            OP_ADDI:  begin cls_o = CL_I;   ext_op_o = EXT_SIGN; end
            OP_SLTI:  begin cls_o = CL_I;   ext_op_o = EXT_SIGN; alu_op_o = ALU_SLT; end
            OP_ANDI:  begin cls_o = CL_I;   alu_op_o = ALU_AND; end
            OP_ORI:   begin cls_o = CL_I;   alu_op_o = ALU_OR;  end
            OP_LUI:   begin cls_o = CL_I;   ext_op_o = EXT_LUI;  alu_op_o = ALU_LUI; end
            OP_LW:    begin cls_o = CL_LW;  ext_op_o = EXT_SIGN; end
            OP_SW:    begin cls_o = CL_SW;  ext_op_o = EXT_SIGN; end
            OP_BEQ:   begin cls_o = CL_BEQ; ext_op_o = EXT_SIGN; end
            OP_BNE:   begin cls_o = CL_BNE; ext_op_o = EXT_SIGN; end
            OP_J:     cls_o = CL_J;
            default:  cls_o = CL_ILL;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : multi-cycle fetch/decode/execute control FSM for MicroCPU.
//                   MEM_READY_EN stalls FETCH/MEM_RD/MEM_WR on MemReady.
// Revision        : 1.0
// ============================================================================
module multicycle_ctrl
    import mcpu_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FN_W = 6,
    parameter int ST_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    multicycle_ctrl_if.master bus
);
    state_t     state_q;
    cls_t       w_cls;
    logic [1:0] w_ext;
    logic [2:0] w_alu_i;
    logic       w_mem_rdy;

`ifdef MEM_READY_EN
    assign w_mem_rdy = bus.MemReady;
`else
    assign w_mem_rdy = 1'b1;
`endif

    mcpu_op_decode #(
        .OP_W (OP_W),
        .FN_W (FN_W)
    ) u_dec (
        .op_i     (bus.Op),
        .funct_i  (bus.Funct),
        .cls_o    (w_cls),
        .ext_op_o (w_ext),
        .alu_op_o (w_alu_i)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (bus.Go) state_q <= S_FETCH;
                S_FETCH:    if (w_mem_rdy) state_q <= S_DECODE;
                S_DECODE: begin
                    case (w_cls)
                        CL_R:          state_q <= S_EXEC_R;
                        CL_I:          state_q <= S_EXEC_I;
                        CL_LW, CL_SW:  state_q <= S_MEM_ADDR;
                        CL_BEQ, CL_BNE: state_q <= S_BRANCH;
                        CL_J:          state_q <= S_JUMP;
                        CL_SYS:        state_q <= S_HALT;
                        default:       state_q <= S_FETCH;
                    endcase
                end
                S_EXEC_R:   state_q <= S_WB_R;
                S_EXEC_I:   state_q <= S_WB_I;
                S_MEM_ADDR: state_q <= (w_cls == CL_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (w_mem_rdy) state_q <= S_MEM_WB;
                S_MEM_WR:   if (w_mem_rdy) state_q <= S_FETCH;
                S_HALT:     state_q <= S_HALT;
                S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state so an async reset kills strobes at once.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemToReg  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_B;
        bus.ALUOp     = ALU_ADD;
        bus.ExtOp     = EXT_ZERO;
        bus.PCSrc     = PCS_ALU;
        bus.Halted    = 1'b0;
        bus.IllegalOp = 1'b0;
        bus.State     = ST_W'(state_q);
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = w_mem_rdy;
                bus.PCWrite = w_mem_rdy;
                bus.ALUSrcB = SRCB_FOUR;
            end
            S_DECODE: begin
                bus.ALUSrcB   = SRCB_IMM_SH;
                bus.ExtOp     = EXT_SIGN;
                bus.IllegalOp = (w_cls == CL_ILL);
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
                bus.ExtOp   = w_ext;
            end
            S_WB_R: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                bus.ExtOp    = w_ext;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = w_alu_i;
                bus.ExtOp   = w_ext;
            end
            S_WB_I: begin
                bus.RegWrite = 1'b1;
                bus.ExtOp    = w_ext;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ExtOp   = w_ext;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.ExtOp   = w_ext;
            end
            S_MEM_WB: begin
                bus.MemToReg = 1'b1;
                bus.RegWrite = 1'b1;
                bus.ExtOp    = w_ext;
            end
            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.ExtOp    = w_ext;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_SUB;
                bus.PCSrc   = PCS_ALUOUT;
                bus.PCWrite = (w_cls == CL_BNE) ? ~bus.Zero : bus.Zero;
                bus.ExtOp   = w_ext;
            end
            S_JUMP: begin
                bus.PCSrc   = PCS_JUMP;
                bus.PCWrite = 1'b1;
                bus.ExtOp   = w_ext;
            end
            S_HALT:  bus.Halted = 1'b1;
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : directed self-checking bench for multicycle_ctrl.
//                      MEM_READY_EN enables the memory-stall scenario.
// Revision           : 1.0
// ============================================================================
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    logic [22:0] exp_v;
    logic [22:0] obs;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OP_W(6), .FN_W(6), .ST_W(4)) bus ();
    multicycle_ctrl #(.OP_W(6), .FN_W(6), .ST_W(4)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2, ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_WB_R = 4'd4,  ST_EXEC_I = 4'd5, ST_WB_I = 4'd6,   ST_MADDR = 4'd7;
    localparam logic [3:0] ST_MRD = 4'd8,   ST_MWB = 4'd9,    ST_MWR = 4'd10,   ST_BR = 4'd11;
    localparam logic [3:0] ST_JUMP = 4'd12, ST_HALT = 4'd13;

    // strobe byte order: PCWrite IRWrite MemRead MemWrite RegWrite RegDst MemToReg ALUSrcA
    assign obs = {bus.State, bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
                  bus.RegDst, bus.MemToReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ExtOp,
                  bus.PCSrc, bus.Halted, bus.IllegalOp};

    function automatic logic [22:0] ev(input logic [3:0] st, input logic [7:0] strb,
                                       input logic [1:0] sb, input logic [2:0] aop,
                                       input logic [1:0] ext, input logic [1:0] pcs,
                                       input logic h, input logic ill);
        return {st, strb, sb, aop, ext, pcs, h, ill};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.Go = 1'b1; bus.Op = 6'h0D; bus.Funct = 6'h00; bus.Zero = 1'b0;
`ifdef MEM_READY_EN
        bus.MemReady = 1'b1;
`endif
        tick; tick;
        exp_v = ev(ST_IDLE, 8'h00, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
        rst = 1'b0;
        tick; bus.Go = 1'b0;
        exp_v = ev(ST_FETCH, 8'b1110_0000, 2'b01, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL go_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_ori;
        bus.Op = 6'h0D; bus.Go = 1'b1;
        tick;
        exp_v = ev(ST_DECODE, 8'h00, 2'b11, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL ori_decode: got %h want %h", obs, exp_v); end
        tick;
        exp_v = ev(ST_EXEC_I, 8'b0000_0001, 2'b10, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL ori_exec: got %h want %h", obs, exp_v); end
        tick;
        exp_v = ev(ST_WB_I, 8'b0000_1000, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL ori_wb: got %h want %h", obs, exp_v); end
        tick; bus.Go = 1'b0;
        checks++;
        if (bus.State !== ST_FETCH) begin fails++; $display("FAIL ori_latency: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    task automatic test_lw_sw;
        bus.Op = 6'h23;
        tick; tick;
        exp_v = ev(ST_MADDR, 8'b0000_0001, 2'b10, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL lw_addr: got %h want %h", obs, exp_v); end
        tick;
        exp_v = ev(ST_MRD, 8'b0010_0000, 2'b00, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL lw_rd: got %h want %h", obs, exp_v); end
        tick;
        exp_v = ev(ST_MWB, 8'b0000_1010, 2'b00, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL lw_wb: got %h want %h", obs, exp_v); end
        tick; checks++;
        if (bus.State !== ST_FETCH) begin fails++; $display("FAIL lw_latency: got %0d want %0d", bus.State, ST_FETCH); end
        bus.Op = 6'h2B;
        tick; tick; tick;
        exp_v = ev(ST_MWR, 8'b0001_0000, 2'b00, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL sw_wr: got %h want %h", obs, exp_v); end
        tick; checks++;
        if (bus.State !== ST_FETCH || bus.MemWrite !== 1'b0) begin
            fails++; $display("FAIL sw_one_cycle: got state %0d memwrite %b want 1/0", bus.State, bus.MemWrite);
        end
    endtask

    task automatic test_branch;
        bus.Op = 6'h04; bus.Zero = 1'b1;
        tick; tick;
        exp_v = ev(ST_BR, 8'b1000_0001, 2'b00, 3'd1, 2'b01, 2'b01, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL beq_taken: got %h want %h", obs, exp_v); end
        tick; checks++;
        if (bus.State !== ST_FETCH) begin fails++; $display("FAIL beq_latency: got %0d want %0d", bus.State, ST_FETCH); end
        bus.Op = 6'h05;
        tick; tick;
        exp_v = ev(ST_BR, 8'b0000_0001, 2'b00, 3'd1, 2'b01, 2'b01, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL bne_not_taken: got %h want %h", obs, exp_v); end
        bus.Zero = 1'b0; #1; checks++;
        if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL bne_taken: got %b want 1", bus.PCWrite); end
        tick; checks++;
        if (bus.State !== ST_FETCH) begin fails++; $display("FAIL bne_latency: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    task automatic test_rtype_jump;
        bus.Op = 6'h00; bus.Funct = 6'h20;
        tick; tick;
        exp_v = ev(ST_EXEC_R, 8'b0000_0001, 2'b00, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL r_exec: got %h want %h", obs, exp_v); end
        tick;
        exp_v = ev(ST_WB_R, 8'b0000_1100, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL r_wb: got %h want %h", obs, exp_v); end
        tick; bus.Op = 6'h02;
        tick; tick;
        exp_v = ev(ST_JUMP, 8'b1000_0000, 2'b00, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL jump: got %h want %h", obs, exp_v); end
        tick; checks++;
        if (bus.State !== ST_FETCH) begin fails++; $display("FAIL j_latency: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    task automatic test_illegal_halt;
        bus.Op = 6'h3F;
        tick;
        exp_v = ev(ST_DECODE, 8'h00, 2'b11, 3'd0, 2'b01, 2'b00, 1'b0, 1'b1); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL illegal_pulse: got %h want %h", obs, exp_v); end
        tick; checks++;
        if (bus.State !== ST_FETCH || bus.IllegalOp !== 1'b0) begin
            fails++; $display("FAIL illegal_return: got state %0d ill %b want 1/0", bus.State, bus.IllegalOp);
        end
        bus.Op = 6'h00; bus.Funct = 6'h0C;
        tick; tick;
        exp_v = ev(ST_HALT, 8'h00, 2'b00, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL halt: got %h want %h", obs, exp_v); end
        bus.Go = 1'b1; tick; bus.Go = 1'b0; tick; tick; checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL halt_go_ignored: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; tick; rst = 1'b0; bus.Go = 1'b1; bus.Op = 6'h2B;
        tick; bus.Go = 1'b0;
        tick; tick; tick; checks++;
        if (bus.State !== ST_MWR || bus.MemWrite !== 1'b1) begin
            fails++; $display("FAIL mid_setup: got state %0d memwrite %b want 10/1", bus.State, bus.MemWrite);
        end
        #1 rst = 1'b1;
        #1;
        exp_v = ev(ST_IDLE, 8'h00, 2'b00, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL mid_reset_abort: got %h want %h", obs, exp_v); end
        tick; rst = 1'b0;
    endtask

`ifdef MEM_READY_EN
    task automatic test_mem_ready;
        bus.Go = 1'b1; bus.Op = 6'h23;
        tick; bus.Go = 1'b0; bus.MemReady = 1'b0; #1;
        exp_v = ev(ST_FETCH, 8'b0010_0000, 2'b01, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL fetch_stall: got %h want %h", obs, exp_v); end
        tick; checks++;
        if (bus.State !== ST_FETCH) begin fails++; $display("FAIL fetch_hold: got %0d want %0d", bus.State, ST_FETCH); end
        bus.MemReady = 1'b1;
        tick; tick; tick; bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; checks++;
            if (bus.State !== ST_MRD || bus.RegWrite !== 1'b0) begin
                fails++; $display("FAIL mem_rd_hold: got state %0d regwrite %b want 8/0", bus.State, bus.RegWrite);
            end
        end
        bus.MemReady = 1'b1;
        tick; checks++;
        if (bus.State !== ST_MWB || bus.RegWrite !== 1'b1) begin
            fails++; $display("FAIL mem_rd_release: got state %0d regwrite %b want 9/1", bus.State, bus.RegWrite);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_ori;
        test_lw_sw;
        test_branch;
        test_rtype_jump;
        test_illegal_halt;
        test_reset_mid;
`ifdef MEM_READY_EN
        test_mem_ready;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset MicroCPU.
- Sequences fetch/decode/execute/memory/writeback and drives the datapath selects: PC, IR, register file, memory, ALU muxes, and the immediate extender mode (ExtOp: zero/sign/LUI).
- Replaces the single-cycle combinational controller; the datapath around it is unchanged except for the added IR/MDR/A/B/ALUOut registers.

Parameters:
- OP_W, 6, opcode field width
- FN_W, 6, funct field width
- ST_W, 4, state register width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Go  in  1  start pulse; sampled only in IDLE
- Op  in  OP_W  IR[31:26]
- Funct  in  FN_W  IR[5:0]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR load enable
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  1 = MDR, 0 = ALUOut
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  3  00 add, 01 sub, 10 funct-decode, 11 and, 100 or, 101 slt, 110 lui-pass
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 LUI (imm<<16)
- PCSrc  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target
- Halted  out  1  high in HALT
- IllegalOp  out  1  one-cycle pulse in DECODE on an unknown opcode
- State  out  ST_W  current state, for debug

Behaviour:
- Only the state register is sequential. All other outputs are Moore-decoded from State; ExtOp and ALUOp also use Op/Funct.
- Reset (async): State = IDLE immediately. All outputs are 0 (ExtOp = 00, State = 0). A reset mid-instruction aborts it: no further PC, register or memory writes.
- State sequence:
  - IDLE: all strobes 0. Go=1 -> FETCH.
  - FETCH: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00, PCWrite=1 -> DECODE.
  - DECODE: ALUSrcB=11, ExtOp=01, ALUOp=add (precomputes branch target). Dispatch:
    - R-type: -> EXEC_R
    - ADDI/SLTI/ANDI/ORI/LUI: -> EXEC_I
    - LW/SW: -> MEM_ADDR
    - BEQ/BNE: -> BRANCH
    - J: -> JUMP
    - SYSCALL (Op=0, Funct=0x0C): -> HALT
    - any other opcode: -> FETCH with IllegalOp=1 (executes as a NOP)
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R.
  - WB_R: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp by opcode -> WB_I.
  - WB_I: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=01, ALUOp=add. LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD: MemRead=1 -> MEM_WB.
  - MEM_WB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
  - MEM_WR: MemWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01. PCWrite = Zero for BEQ, ~Zero for BNE -> FETCH.
  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
  - HALT: Halted=1, no strobes. Exits only on Reset. Go is ignored.
- ExtOp mapping, held constant through every post-DECODE state of the instruction:
  - ADDI/SLTI/LW/SW/BEQ/BNE: 01
  - ANDI/ORI: 00
  - LUI: 10
- Latency in cycles, FETCH to the next FETCH: R 4, I-ALU 4, LW 5, SW 4, branch 3, J 3.
- Go is ignored outside IDLE.
- At most one of MemRead/MemWrite is asserted in any state.
- RegWrite and MemWrite are never asserted in the same cycle.

Optional Feature:
- Macro: MEM_READY_EN.
- Defined: adds input MemReady (1 bit). FETCH, MEM_RD and MEM_WR hold their state and outputs until MemReady=1, then advance. PCWrite and IRWrite in FETCH qualify on MemReady, so they assert for exactly one cycle.
- Undefined: no port; memory is assumed single-cycle.

Decomposition:
- Package mcpu_ctrl_pkg holds:
  - opcode and funct constants (OP_RTYPE, OP_ADDI, OP_LW, FN_SYSCALL, ...)
  - state encodings
  - ExtOp, ALUSrcB, ALUOp and PCSrc encodings
- Sub-module mcpu_op_decode: combinational Op/Funct -> instruction class, ExtOp and I-type ALUOp. Shared with the ALU control.

Test Plan:
- Reset high, Go=1 -> State=IDLE, all strobes 0. Release reset, pulse Go -> FETCH next cycle with PCWrite=IRWrite=MemRead=1.
- ORI (Op=0x0D) -> DECODE then EXEC_I with ExtOp=00, ALUSrcB=10. WB_I has RegWrite=1, RegDst=0. Back to FETCH after 4 cycles.
- LW (Op=0x23), then SW (Op=0x2B):
  - LW: MEM_ADDR ExtOp=01; MEM_RD MemRead=1; MEM_WB MemToReg=1, RegWrite=1; 5 cycles total.
  - SW: MemWrite=1 for exactly 1 cycle.
- BEQ (Op=0x04) with Zero=1 -> PCWrite=1, PCSrc=01 in BRANCH. BNE with Zero=1 -> PCWrite=0. Both take 3 cycles.
- Op=0x3F -> IllegalOp pulses 1 cycle, returns to FETCH. SYSCALL -> HALT with Halted=1; Go pulses are ignored.
- Reset asserted in MEM_WR -> MemWrite drops in the same cycle and State=IDLE. MEM_READY_EN variant: MemReady low for 3 cycles in MEM_RD -> state is held, RegWrite is not asserted early.
